// File: rtl/space_pkg.sv
// Shared constants and state encoding for the enemy-formation blocks.
package space_pkg;

  localparam int X_W   = 11;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LANDED = 1'b1
  } state_t;

endpackage

// File: rtl/frame_divider.sv
// Divides frame ticks down to formation step events with a kill-shortened period.
// Optional feature macro: FORMATION_SPEEDUP_EN (kill shortens the period when defined).
module frame_divider #(
  parameter int DIV_INIT = 4,
  parameter int DIV_MIN  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic enable,
  input  logic kill,
  input  logic clear,
  output logic step_event
);

  localparam int CNT_W = (DIV_INIT < 2) ? 1 : $clog2(DIV_INIT + 1);
  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(DIV_INIT);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;

  // Comparing against period-1 lets a count stranded above a shortened period fire at once.
  assign step_event = frame_tick && enable && (cnt >= period - ONE);

`ifdef FORMATION_SPEEDUP_EN
  localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(DIV_MIN);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      period <= PERIOD_INIT;
    end else if (kill && (period > PERIOD_MIN)) begin
      period <= period - ONE;
    end
  end
`else
  logic unused_kill;
  assign unused_kill = kill;
  assign period      = PERIOD_INIT;
`endif

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (frame_tick && enable) begin
      cnt <= step_event ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/formation_mover.sv
// Enemy-formation motion controller: steps the formation sideways, bounces, descends and flags landing.
// Optional feature macro: FORMATION_SPEEDUP_EN (kill pulses speed up the step rate).
module formation_mover #(
  parameter int N_ROWS    = 3,
  parameter int X_W       = space_pkg::X_W,
  parameter int X_MIN     = 16,
  parameter int X_MAX     = 400,
  parameter int STEP      = 4,
  parameter int DROP      = 16,
  parameter int Y_START   = 64,
  parameter int ROW_PITCH = 40,
  parameter int Y_LIMIT   = 400,
  parameter int DIV_INIT  = 4,
  parameter int DIV_MIN   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    enable,
  input  logic                    kill,
  input  logic                    restart,
  output logic [X_W-1:0]          pos_x,
  output logic [N_ROWS*X_W-1:0]   row_y,
  output logic                    dir,
  output logic                    step_pulse,
  output logic                    landed
);

  import space_pkg::*;

  localparam int EW = X_W + 2;

  state_t         state;
  logic [X_W-1:0] y_base;
  logic           step_event;
  logic [X_W:0]   nx;
  logic           in_range;
  logic [X_W-1:0] y_next;
  logic [EW-1:0]  bottom_next;

  frame_divider #(
    .DIV_INIT (DIV_INIT),
    .DIV_MIN  (DIV_MIN)
  ) u_divider (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (enable && (state == ST_RUN)),
    .kill       (kill),
    .clear      (restart),
    .step_event (step_event)
  );

  function automatic logic [N_ROWS*X_W-1:0] pack_rows(input logic [X_W-1:0] base);
    pack_rows = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      pack_rows[i*X_W +: X_W] = base + X_W'(i * ROW_PITCH);
    end
  endfunction

  // One extra bit on nx exposes both underflow past zero and overflow past the right limit.
  always_comb begin
    nx          = (dir == DIR_RIGHT) ? ({1'b0, pos_x} + (X_W+1)'(STEP))
                                     : ({1'b0, pos_x} - (X_W+1)'(STEP));
    in_range    = (nx >= (X_W+1)'(X_MIN)) && (nx <= (X_W+1)'(X_MAX));
    y_next      = y_base + X_W'(DROP);
    bottom_next = EW'(y_next) + EW'((N_ROWS - 1) * ROW_PITCH);
  end

  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      pos_x      <= X_W'(X_MIN);
      dir        <= DIR_RIGHT;
      y_base     <= X_W'(Y_START);
      row_y      <= pack_rows(X_W'(Y_START));
      step_pulse <= 1'b0;
      landed     <= 1'b0;
      state      <= ST_RUN;
    end else begin
      step_pulse <= step_event;
      if (step_event) begin
        if (in_range) begin
          pos_x <= nx[X_W-1:0];
        end else begin
          // A bounce clamps to the limit just crossed, which is the one ahead of the current direction.
          pos_x  <= (dir == DIR_RIGHT) ? X_W'(X_MAX) : X_W'(X_MIN);
          dir    <= ~dir;
          y_base <= y_next;
          row_y  <= pack_rows(y_next);
          if (bottom_next >= EW'(Y_LIMIT)) begin
            state  <= ST_LANDED;
            landed <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_formation_mover.sv
// Self-checking bench for formation_mover: directed scenarios plus randomized traffic against a behavioural model.
module tb_formation_mover;

  localparam int N_ROWS = 3;
  localparam int X_W    = 11;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  frame_tick;
  logic                  enable;
  logic                  kill;
  logic                  restart;
  logic [X_W-1:0]        pos_x;
  logic [N_ROWS*X_W-1:0] row_y;
  logic                  dir;
  logic                  step_pulse;
  logic                  landed;

  always #5 clk = ~clk;

  formation_mover dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (enable),
    .kill       (kill),
    .restart    (restart),
    .pos_x      (pos_x),
    .row_y      (row_y),
    .dir        (dir),
    .step_pulse (step_pulse),
    .landed     (landed)
  );

  int vecCount  = 0;
  int missCount = 0;
  int killCount = 0;

  // Behavioural model: whole-pixel position, ticks seen since last step, plain integer period.
  int mPos, mY, mPeriod, mTicks;
  bit mDir, mLanded, mPulse;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] rowsOf(input int base);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < N_ROWS; i++) r[i*X_W +: X_W] = 11'(base + i * 40);
    return r;
  endfunction

  task automatic modelReset();
    mPos = 16; mDir = 1'b1; mY = 64; mPeriod = 4; mTicks = 0; mLanded = 1'b0; mPulse = 1'b0;
  endtask

  task automatic modelClock(input bit rstN, input bit ft, input bit en, input bit kl, input bit rs);
    int nx;
    if (!rstN || rs) begin
      modelReset();
    end else begin
      mPulse = 1'b0;
      if (ft && en && !mLanded) begin
        mTicks++;
        if (mTicks >= mPeriod) begin
          mTicks = 0;
          mPulse = 1'b1;
        end
      end
      if (kl) killCount++;
`ifdef FORMATION_SPEEDUP_EN
      if (kl) mPeriod = (mPeriod - 1 > 1) ? mPeriod - 1 : 1;
`endif
      if (mPulse) begin
        nx = mDir ? mPos + 4 : mPos - 4;
        if (nx >= 16 && nx <= 400) begin
          mPos = nx;
        end else begin
          mPos = mDir ? 400 : 16;
          mDir = !mDir;
          mY   = mY + 16;
          if (mY + (N_ROWS - 1) * 40 >= 400) mLanded = 1'b1;
        end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("pos_x", pos_x, mPos);
    checkOutput("dir", dir, mDir);
    checkOutput("row_y", row_y, rowsOf(mY));
    checkOutput("step_pulse", step_pulse, mPulse);
    checkOutput("landed", landed, mLanded);
  endtask

  task automatic applyStimulus(input bit rstN, input bit ft, input bit en, input bit kl, input bit rs);
    reset = rstN; frame_tick = ft; enable = en; kill = kl; restart = rs;
    @(posedge clk);
    modelClock(rstN, ft, en, kl, rs);
    @(negedge clk);
    checkAll();
  endtask

  task automatic tick(input bit en);
    applyStimulus(1'b1, 1'b1, en, 1'b0, 1'b0);
  endtask

  initial begin
    logic [32:0]    expRows;
    logic [X_W-1:0] heldPos;
    int             guard;

    reset = 1'b0; frame_tick = 1'b0; enable = 1'b0; kill = 1'b0; restart = 1'b0;
    modelReset();

    // Reset wins over a simultaneous frame tick.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expRows = {11'd144, 11'd104, 11'd64};
    checkOutput("rst_pos_x", pos_x, 16);
    checkOutput("rst_dir", dir, 1);
    checkOutput("rst_row_y", row_y, expRows);
    checkOutput("rst_landed", landed, 0);
    checkOutput("rst_step_pulse", step_pulse, 0);

    for (int i = 1; i <= 4; i++) begin
      tick(1'b1);
      if (i < 4) checkOutput("early_tick_no_step", step_pulse, 0);
      else begin
        checkOutput("fourth_tick_step", step_pulse, 1);
        checkOutput("first_step_pos", pos_x, 20);
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    guard = 0;
    while (mPos != 400 && guard < 2000) begin tick(1'b1); guard++; end
    if (guard >= 2000) checkOutput("reach_right_timeout", 0, 1);
    guard = 0;
    do begin tick(1'b1); guard++; end while (!mPulse && guard < 10);
    expRows = {11'd160, 11'd120, 11'd80};
    checkOutput("bounce_pos_x", pos_x, 400);
    checkOutput("bounce_dir", dir, 0);
    checkOutput("bounce_row_y", row_y, expRows);
    guard = 0;
    do begin tick(1'b1); guard++; end while (!mPulse && guard < 10);
    checkOutput("after_bounce_pos_x", pos_x, 396);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef FORMATION_SPEEDUP_EN
    for (int i = 0; i < 3; i++) begin tick(1'b1); checkOutput("fast_step", step_pulse, 1); end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin tick(1'b1); checkOutput("min_period_step", step_pulse, 1); end
`else
    for (int i = 1; i <= 4; i++) begin tick(1'b1); checkOutput("kill_ignored_step", step_pulse, i == 4); end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin tick(1'b1); checkOutput("kill_ignored_step2", step_pulse, i == 4); end
`endif

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("restart_pos_x", pos_x, 16);

    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    tick(1'b1);
    checkOutput("reenable_first_tick", step_pulse, 0);
    tick(1'b1);
    checkOutput("reenable_second_tick", step_pulse, 1);

    guard = 0;
    while (!mLanded && guard < 20000) begin tick(1'b1); guard++; end
    if (guard >= 20000) checkOutput("landing_timeout", 0, 1);
    checkOutput("landed_flag", landed, 1);
    checkOutput("landed_y_base", row_y[X_W-1:0], 320);
    heldPos = pos_x;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      checkOutput("landed_frozen_pos", pos_x, heldPos);
      checkOutput("landed_no_step", step_pulse, 0);
    end

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    expRows = {11'd144, 11'd104, 11'd64};
    checkOutput("restart_landed", landed, 0);
    checkOutput("restart_dir", dir, 1);
    checkOutput("restart_row_y", row_y, expRows);
    for (int i = 1; i <= 4; i++) begin tick(1'b1); checkOutput("restart_period", step_pulse, i == 4); end

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) != 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) != 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 99) == 0);
    end

    $display("[TB] kill pulses applied: %0d", killCount);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
